// File: rtl/program_loader.sv
// program_loader: byte-stream bootloader for the instruction RAM.
// Parses START, LEN_LO, LEN_HI, N x (DATA_LO, DATA_HI), CHK frames from the
// UART receiver and turns each halfword into a one-cycle write on the memory
// port. The core is held in reset through load_active_o while a frame is open.
module program_loader #(
  parameter logic [7:0]  START_BYTE     = 8'hA5,
  parameter int          MAX_HALFWORDS  = 512,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_byte_i,
  output logic        program_mem_write_en_o,
  output logic [15:0] instruction_o,
  output logic [31:0] instruction_addr_o,
  output logic        load_active_o,
  output logic        load_done_o,
  output logic        load_error_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t        state;
  logic [7:0]    len_lo;
  logic [15:0]   len;
  logic [7:0]    data_lo;
  logic [7:0]    chk;
  logic [15:0]   index;
  logic [TW-1:0] timer;

  logic [15:0]   len_next;
  logic [15:0]   index_next;
  logic [31:0]   write_addr;
  logic          in_frame;
  logic          timed_out;

  // Next-value helpers shared by the frame FSM below.
  always_comb begin
    len_next   = {rx_byte_i, len_lo};
    index_next = index + 16'd1;
    write_addr = BASE_ADDR + {15'd0, index, 1'b0};
    in_frame   = (state == LEN_LO) || (state == LEN_HI) || (state == DATA_LO) ||
                 (state == DATA_HI) || (state == CHECK);
    // The timer holds the idle cycles already counted; this cycle would be one more.
    timed_out  = in_frame && !rx_valid_i && (timer == TW'(TIMEOUT_CYCLES - 1));
  end

  // Frame FSM: parses bytes, accumulates the checksum, issues registered writes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state                  <= IDLE;
      len_lo                 <= '0;
      len                    <= '0;
      data_lo                <= '0;
      chk                    <= '0;
      index                  <= '0;
      timer                  <= '0;
      program_mem_write_en_o <= 1'b0;
      instruction_o          <= '0;
      instruction_addr_o     <= BASE_ADDR;
      load_active_o          <= 1'b0;
      load_done_o            <= 1'b0;
      load_error_o           <= 1'b0;
    end else begin
      program_mem_write_en_o <= 1'b0;

      if (in_frame) begin
        timer <= rx_valid_i ? '0 : timer + TW'(1);
      end

      if (timed_out) begin
        // Writes already issued stay in memory; only the frame is abandoned.
        state         <= ERROR;
        load_active_o <= 1'b0;
        load_error_o  <= 1'b1;
      end else if (rx_valid_i) begin
        case (state)
          IDLE, DONE, ERROR: begin
            if (rx_byte_i == START_BYTE) begin
              state         <= LEN_LO;
              load_active_o <= 1'b1;
              load_done_o   <= 1'b0;
              load_error_o  <= 1'b0;
              chk           <= '0;
              index         <= '0;
              timer         <= '0;
            end
          end
          LEN_LO: begin
            len_lo <= rx_byte_i;
            chk    <= chk ^ rx_byte_i;
            state  <= LEN_HI;
          end
          LEN_HI: begin
            len <= len_next;
            chk <= chk ^ rx_byte_i;
            if ({16'd0, len_next} > 32'(MAX_HALFWORDS)) begin
              state         <= ERROR;
              load_active_o <= 1'b0;
              load_error_o  <= 1'b1;
            end else if (len_next == 16'd0) begin
              state <= CHECK;
            end else begin
              state <= DATA_LO;
            end
          end
          DATA_LO: begin
            data_lo <= rx_byte_i;
            chk     <= chk ^ rx_byte_i;
            state   <= DATA_HI;
          end
          DATA_HI: begin
            chk                    <= chk ^ rx_byte_i;
            program_mem_write_en_o <= 1'b1;
            instruction_o          <= {rx_byte_i, data_lo};
            instruction_addr_o     <= write_addr;
            index                  <= index_next;
            state                  <= (index_next == len) ? CHECK : DATA_LO;
          end
          CHECK: begin
            load_active_o <= 1'b0;
            if (rx_byte_i == chk) begin
              state       <= DONE;
              load_done_o <= 1'b1;
            end else begin
              state        <= ERROR;
              load_error_o <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a short timeout.
module tb_program_loader;

  logic        clk;
  logic        reset_i;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        wr_en;
  logic [15:0] instr;
  logic [31:0] addr;
  logic        active;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int wr_base  = 0;

  program_loader #(
    .START_BYTE     (8'hA5),
    .MAX_HALFWORDS  (512),
    .BASE_ADDR      (32'h0),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i                  (clk),
    .reset_i                (reset_i),
    .rx_valid_i             (rx_valid),
    .rx_byte_i              (rx_byte),
    .program_mem_write_en_o (wr_en),
    .instruction_o          (instr),
    .instruction_addr_o     (addr),
    .load_active_o          (active),
    .load_done_o            (done),
    .load_error_o           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every write strobe seen on the memory port.
  always @(negedge clk) if (wr_en === 1'b1) wr_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte for exactly one clock; returns on the following negedge.
  task automatic byte_in(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    reset_i  = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_wr_en",  32'(wr_en),  32'd0);
    check("rst_instr",  32'(instr),  32'd0);
    check("rst_addr",   addr,        32'h0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_err",    32'(err),    32'd0);
    reset_i = 1'b0;
    @(negedge clk);

    // Idle noise is ignored
    wr_base = wr_cnt;
    byte_in(8'h00);
    byte_in(8'h55);
    check("idle_active", 32'(active), 32'd0);
    check("idle_writes", 32'(wr_cnt - wr_base), 32'd0);

    // Good two-halfword frame
    wr_base = wr_cnt;
    byte_in(8'hA5);
    check("a_active_on", 32'(active), 32'd1);
    byte_in(8'h02);
    byte_in(8'h00);
    byte_in(8'h34);
    byte_in(8'h12);
    check("a_wr0_en",   32'(wr_en), 32'd1);
    check("a_wr0_data", 32'(instr), 32'h1234);
    check("a_wr0_addr", addr,       32'h0);
    byte_in(8'h78);
    check("a_strobe_one_cycle", 32'(wr_en), 32'd0);
    check("a_instr_hold",       32'(instr), 32'h1234);
    byte_in(8'h56);
    check("a_wr1_en",   32'(wr_en), 32'd1);
    check("a_wr1_data", 32'(instr), 32'h5678);
    check("a_wr1_addr", addr,       32'h2);
    byte_in(8'h0A);
    check("a_done",   32'(done),   32'd1);
    check("a_err",    32'(err),    32'd0);
    check("a_active", 32'(active), 32'd0);
    check("a_writes", 32'(wr_cnt - wr_base), 32'd2);
    byte_in(8'h33);
    check("a_done_sticky", 32'(done), 32'd1);

    // Same frame, bad checksum
    wr_base = wr_cnt;
    byte_in(8'hA5);
    check("b_done_cleared", 32'(done), 32'd0);
    byte_in(8'h02); byte_in(8'h00);
    byte_in(8'h34); byte_in(8'h12);
    byte_in(8'h78); byte_in(8'h56);
    byte_in(8'h0B);
    check("b_err",    32'(err),    32'd1);
    check("b_done",   32'(done),   32'd0);
    check("b_active", 32'(active), 32'd0);
    check("b_writes", 32'(wr_cnt - wr_base), 32'd2);

    // Length 0x0201 exceeds the RAM
    wr_base = wr_cnt;
    byte_in(8'hA5);
    check("c_err_cleared", 32'(err), 32'd0);
    byte_in(8'h01);
    byte_in(8'h02);
    check("c_err",    32'(err),    32'd1);
    check("c_active", 32'(active), 32'd0);
    byte_in(8'h00);
    byte_in(8'h00);
    check("c_writes", 32'(wr_cnt - wr_base), 32'd0);

    // Length 0x0200 is exactly the limit and is accepted
    byte_in(8'hA5);
    byte_in(8'h00);
    byte_in(8'h02);
    check("max_active", 32'(active), 32'd1);
    check("max_err",    32'(err),    32'd0);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;

    // Empty frame
    wr_base = wr_cnt;
    byte_in(8'hA5);
    byte_in(8'h00);
    byte_in(8'h00);
    check("n0_active_chk", 32'(active), 32'd1);
    byte_in(8'h00);
    check("n0_done",   32'(done),   32'd1);
    check("n0_active", 32'(active), 32'd0);
    check("n0_writes", 32'(wr_cnt - wr_base), 32'd0);

    // Partial frame, then silence
    byte_in(8'hA5);
    byte_in(8'h01);
    byte_in(8'h00);
    byte_in(8'h11);
    repeat (15) @(negedge clk);
    check("to_err_early",    32'(err),    32'd0);
    check("to_active_early", 32'(active), 32'd1);
    @(negedge clk);
    check("to_err",    32'(err),    32'd1);
    check("to_active", 32'(active), 32'd0);

    // Recovery frame
    byte_in(8'hA5);
    check("r_err_cleared", 32'(err), 32'd0);
    byte_in(8'h01);
    byte_in(8'h00);
    byte_in(8'hCD);
    byte_in(8'hAB);
    check("r_wr_en",   32'(wr_en), 32'd1);
    check("r_wr_data", 32'(instr), 32'hABCD);
    check("r_wr_addr", addr,       32'h0);
    byte_in(8'h67);
    check("r_done", 32'(done), 32'd1);
    check("r_err",  32'(err),  32'd0);

    // Reset between DATA_LO and DATA_HI
    wr_base = wr_cnt;
    byte_in(8'hA5);
    byte_in(8'h01);
    byte_in(8'h00);
    byte_in(8'h99);
    reset_i = 1'b1;
    @(negedge clk);
    check("mr_wr_en",  32'(wr_en),  32'd0);
    check("mr_active", 32'(active), 32'd0);
    check("mr_done",   32'(done),   32'd0);
    check("mr_instr",  32'(instr),  32'd0);
    check("mr_addr",   addr,        32'h0);
    reset_i = 1'b0;
    byte_in(8'h88);
    check("mr_no_strobe", 32'(wr_en),  32'd0);
    check("mr_idle",      32'(active), 32'd0);
    check("mr_writes",    32'(wr_cnt - wr_base), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream bootloader that writes a program image into instruction memory before the core runs.
- Consumes bytes from the UART receiver as a framed packet: start byte, halfword count, payload, checksum.
- Drives the memory write port: write-enable, 16-bit instruction, 32-bit byte address.
- Holds the pipeline in reset via load_active_o while a load is in progress; reports completion or error.

Parameters:
START_BYTE, 8'hA5, frame-start marker.
MAX_HALFWORDS, 512, largest accepted halfword count (instruction RAM depth).
BASE_ADDR, 32'h0, byte address of the first halfword written.
TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes inside a frame.

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous active-high reset
rx_valid_i  input  1  one-cycle strobe; rx_byte_i is valid this cycle
rx_byte_i  input  8  received byte
program_mem_write_en_o  output  1  one-cycle write strobe to instruction memory
instruction_o  output  16  halfword to write
instruction_addr_o  output  32  byte address of write (even)
load_active_o  output  1  high from start byte accepted until DONE/ERROR; core held in reset
load_done_o  output  1  sticky: last frame loaded and checksum matched
load_error_o  output  1  sticky: last frame failed (checksum, length, timeout)

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset values: all outputs 0; instruction_addr_o = BASE_ADDR; state IDLE; counters and checksum 0.
- Frame format: START_BYTE, LEN_LO, LEN_HI, N×(DATA_LO, DATA_HI), CHK.
  - N = {LEN_HI, LEN_LO}, in halfwords.
  - CHK = XOR of all LEN and DATA bytes. START_BYTE is excluded from CHK.
- States:
  - IDLE: rx byte == START_BYTE -> LEN_LO. load_active_o<=1; clear done/error; clear checksum. Other bytes ignored.
  - LEN_LO: byte -> LEN_HI (store low byte).
  - LEN_HI: store high byte.
    - N > MAX_HALFWORDS -> ERROR.
    - N == 0 -> CHECK.
    - Otherwise -> DATA_LO.
  - DATA_LO: latch low byte -> DATA_HI.
  - DATA_HI: on byte, next cycle:
    - program_mem_write_en_o=1 for exactly one cycle.
    - instruction_o = {hi, lo}.
    - instruction_addr_o = BASE_ADDR + 2*index.
    - Then index++. index==N -> CHECK, else -> DATA_LO.
  - CHECK: byte == running checksum -> DONE (load_done_o<=1), else -> ERROR (load_error_o<=1). load_active_o<=0 in both cases.
  - DONE / ERROR: behave as IDLE. START_BYTE begins a new frame and clears both sticky flags.
- Checksum: XOR each accepted byte in LEN_LO, LEN_HI, DATA_LO and DATA_HI into an 8-bit accumulator.
- Write latency: 1 cycle from the accepted DATA_HI byte to the write strobe.
  - instruction_o and instruction_addr_o hold their values after the strobe until the next write.
- Bytes only advance state on rx_valid_i=1. Back-to-back valid bytes are legal every cycle.
- Timeout: in LEN_LO..CHECK, a cycle counter resets on each rx_valid_i.
  - Reaching TIMEOUT_CYCLES -> ERROR, load_active_o<=0.
  - Writes already issued are not undone.
- START_BYTE value inside a frame is treated as data; no resynchronisation.
- Index is 16 bits. Address arithmetic is 32-bit wrapping; BASE_ADDR + 2*(MAX_HALFWORDS-1) must fit the RAM.
- reset_i mid-frame: return to IDLE immediately. No write strobe in the reset cycle or the cycle after.
- rx_valid_i while a write strobe is outputting: accepted normally; no stall is needed.

Test Plan:
- Reset, then idle bytes 8'h00, 8'h55 -> no write, load_active_o=0, state IDLE.
- Frame A5, 02, 00, 34, 12, 78, 56, CHK=02^00^34^12^78^56=0A:
  - Writes 16'h1234 @ 0x0, then 16'h5678 @ 0x2, one-cycle strobes.
  - load_done_o=1, load_active_o=0 after CHK.
- Same frame with CHK=0B -> both writes occur, load_error_o=1, load_done_o=0.
- Frame with N=0x0201 (>512) -> ERROR after LEN_HI, no writes.
- N=0: A5, 00, 00, 00 -> DONE, no writes.
- Partial frame (A5, 01, 00, 11), then silence for TIMEOUT_CYCLES (set to 16) -> ERROR at cycle 16.
  - A subsequent valid frame loads correctly and clears the error.
- reset_i asserted between DATA_LO and DATA_HI -> no strobe, all outputs at reset values next cycle.
